fetch_stage: RTL and testbench

//   Instruction fetch stage and IF/ID pipeline register of the vector ASIP; directly feeds the decode stage (Instr).

---
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
interface fetch_stage_if #(
  parameter int IW = 28,
  parameter int AW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [IW-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a 2-entry return FIFO and the IF/ID pipeline register.
module fetch_stage #(
  parameter int            IW       = 28,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master imem,
  input  logic          stall_d_i,
  input  logic          flush_d_i,
  input  logic          branch_e_i,
  input  logic [AW-1:0] branch_target_e_i,
  output logic [IW-1:0] instr_d_o,
  output logic [AW-1:0] pc_d_o,
  output logic          valid_d_o
);

  typedef enum logic {FETCH, DROP} state_e;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] drop_addr_q, drop_addr_d;
  entry_t        fifo_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pcd_q, pcd_d;
  logic          valid_q, valid_d;
  logic          req;
  logic          push;
  logic          pop;

  // Request credit comes from free FIFO slots; a redirect with a request still
  // pending must wait out that request (DROP) so the memory handshake stays legal.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    req         = 1'b0;
    push        = 1'b0;
    case (state_q)
      FETCH: begin
        req  = (count_q != 2'd2);
        push = req && imem.ack && !branch_e_i;
        if (push) pc_d = pc_q + AW'(PC_STEP);
        if (branch_e_i && req && !imem.ack) begin
          state_d     = DROP;
          drop_addr_d = pc_q;
        end
      end
      DROP: begin
        req = 1'b1;
        if (imem.ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (branch_e_i) pc_d = branch_target_e_i;
  end

  assign imem.req  = req && !rst_i;
  assign imem.addr = (state_q == DROP) ? drop_addr_q : pc_q;

  assign pop = !branch_e_i && !flush_d_i && !stall_d_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    valid_d  = valid_q;
    if (branch_e_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
    if (branch_e_i || flush_d_i) begin
      instr_d = '0;
      pcd_d   = '0;
      valid_d = 1'b0;
    end else if (!stall_d_i) begin
      if (count_q != 2'd0) begin
        instr_d = fifo_q[rd_ptr_q].instr;
        pcd_d   = fifo_q[rd_ptr_q].pc;
        valid_d = 1'b1;
      end else begin
        instr_d = '0;
        pcd_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      instr_q     <= '0;
      pcd_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      if (push) fifo_q[wr_ptr_q] <= '{instr: imem.rdata, pc: pc_q};
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      valid_q     <= valid_d;
    end
  end

  assign instr_d_o = instr_q;
  assign pc_d_o    = pcd_q;
  assign valid_d_o = valid_q;

  // Credit gating must make a push into a full FIFO impossible.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;
  localparam int IW = 28;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic          stallD;
  logic          flushD;
  logic          branchE;
  logic [AW-1:0] branchTargetE;
  logic [IW-1:0] instrD;
  logic [AW-1:0] pcD;
  logic          validD;

  int            latency;
  int            waitCnt;
  int            assertCount;
  int            failCount;

  fetch_stage_if #(.IW(IW), .AW(AW)) bus ();

  fetch_stage #(.IW(IW), .AW(AW), .RESET_PC('0), .PC_STEP(4)) dut (
    .clk_i             (clock),
    .rst_i             (reset),
    .imem              (bus),
    .stall_d_i         (stallD),
    .flush_d_i         (flushD),
    .branch_e_i        (branchE),
    .branch_target_e_i (branchTargetE),
    .instr_d_o         (instrD),
    .pc_d_o            (pcD),
    .valid_d_o         (validD)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns word (addr/4 + 1) after 'latency' cycles of a held request.
  always @(posedge clock or posedge reset) begin
    if (reset) waitCnt <= 0;
    else if (bus.req && !bus.ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  assign bus.ack   = bus.req && (waitCnt == latency);
  assign bus.rdata = IW'((bus.addr >> 2) + 32'd1);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic flush, input logic branch,
                               input logic [AW-1:0] target);
    stallD        = stall;
    flushD        = flush;
    branchE       = branch;
    branchTargetE = target;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input int lat);
    reset   = 1'b1;
    latency = lat;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    latency     = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_valid", 64'(validD), 64'd0);
    checkOutput("rst_instr", 64'(instrD), 64'd0);
    checkOutput("rst_pcd", 64'(pcD), 64'd0);
    checkOutput("rst_req", 64'(bus.req), 64'd0);
    checkOutput("rst_addr", 64'(bus.addr), 64'd0);
    reset = 1'b0;
    #1;

    $display("[TB] test 1: zero-latency streaming");
    checkOutput("t1_c0_req", 64'(bus.req), 64'd1);
    checkOutput("t1_c0_addr", 64'(bus.addr), 64'h0);
    tick();
    checkOutput("t1_c1_addr", 64'(bus.addr), 64'h4);
    checkOutput("t1_c1_valid", 64'(validD), 64'd0);
    tick();
    checkOutput("t1_c2_valid", 64'(validD), 64'd1);
    checkOutput("t1_c2_instr", 64'(instrD), 64'h1);
    checkOutput("t1_c2_pcd", 64'(pcD), 64'h0);
    checkOutput("t1_c2_addr", 64'(bus.addr), 64'h8);
    tick();
    checkOutput("t1_c3_instr", 64'(instrD), 64'h2);
    checkOutput("t1_c3_pcd", 64'(pcD), 64'h4);

    $display("[TB] test 2: decode stall fills the FIFO");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_stall_instr", 64'(instrD), 64'h2);
      checkOutput("t2_stall_req", 64'(bus.req), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t2_r0_instr", 64'(instrD), 64'h3);
    checkOutput("t2_r0_pcd", 64'(pcD), 64'h8);
    checkOutput("t2_r0_addr", 64'(bus.addr), 64'h10);
    tick();
    checkOutput("t2_r1_instr", 64'(instrD), 64'h4);
    checkOutput("t2_r1_pcd", 64'(pcD), 64'hC);
    tick();
    checkOutput("t2_r2_instr", 64'(instrD), 64'h5);
    checkOutput("t2_r2_pcd", 64'(pcD), 64'h10);

    $display("[TB] test 3: redirect during an outstanding request");
    doReset(3);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t3_c8_addr", 64'(bus.addr), 64'h8);
    tick();
    checkOutput("t3_c9_instr", 64'(instrD), 64'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("t3_drop_req", 64'(bus.req), 64'd1);
    checkOutput("t3_drop_addr", 64'(bus.addr), 64'h8);
    checkOutput("t3_drop_valid", 64'(validD), 64'd0);
    tick();
    checkOutput("t3_drop_addr2", 64'(bus.addr), 64'h8);
    tick();
    checkOutput("t3_new_addr", 64'(bus.addr), 64'h100);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_wait_valid", 64'(validD), 64'd0);
      tick();
    end
    checkOutput("t3_valid", 64'(validD), 64'd1);
    checkOutput("t3_instr", 64'(instrD), 64'h41);
    checkOutput("t3_pcd", 64'(pcD), 64'h100);

    $display("[TB] test 4: redirect in the ack cycle");
    doReset(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("t4_addr", 64'(bus.addr), 64'h200);
    checkOutput("t4_c1_valid", 64'(validD), 64'd0);
    tick();
    checkOutput("t4_c2_valid", 64'(validD), 64'd0);
    tick();
    checkOutput("t4_instr", 64'(instrD), 64'h81);
    checkOutput("t4_pcd", 64'(pcD), 64'h200);

    $display("[TB] test 5: flush with a full FIFO");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t5_full_req", 64'(bus.req), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick();
    checkOutput("t5_bub_valid", 64'(validD), 64'd0);
    checkOutput("t5_bub_instr", 64'(instrD), 64'd0);
    checkOutput("t5_bub_pcd", 64'(pcD), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t5_head_instr", 64'(instrD), 64'h82);
    checkOutput("t5_head_pcd", 64'(pcD), 64'h204);
    checkOutput("t5_head_valid", 64'(validD), 64'd1);

    $display("[TB] test 6: asynchronous reset with a full FIFO");
    latency = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t6_full_req", 64'(bus.req), 64'd0);
    checkOutput("t6_held_instr", 64'(instrD), 64'h82);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_valid", 64'(validD), 64'd0);
    checkOutput("t6_async_instr", 64'(instrD), 64'd0);
    checkOutput("t6_async_pcd", 64'(pcD), 64'd0);
    checkOutput("t6_async_req", 64'(bus.req), 64'd0);
    checkOutput("t6_async_addr", 64'(bus.addr), 64'd0);
    doReset(0);
    checkOutput("t6_restart_addr", 64'(bus.addr), 64'h0);
    checkOutput("t6_restart_req", 64'(bus.req), 64'd1);
    tick();
    tick();
    checkOutput("t6_instr", 64'(instrD), 64'h1);
    checkOutput("t6_pcd", 64'(pcD), 64'h0);

    $display("[TB] test 7: PC wrap at the top of the address space");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("t7_top_addr", 64'(bus.addr), 64'hFFFF_FFFC);
    tick();
    checkOutput("t7_wrap_addr", 64'(bus.addr), 64'h0);
    tick();
    checkOutput("t7_valid", 64'(validD), 64'd1);
    checkOutput("t7_pcd", 64'(pcD), 64'hFFFF_FFFC);
    checkOutput("t7_instr", 64'(instrD), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
